branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Dynamic branch predictor beside the fetch stage, gated by the CPU-level bp_enable input.
- IF presents the fetch PC and receives a same-cycle taken/target prediction.
- EX reports each resolved conditional branch back to train the tables.
- Holds a direct-mapped BTB with a 2-bit saturating counter per entry, plus performance counters for branches and mispredicts.

Parameters:
- IDX_W, 4: index width; 2^IDX_W entries (16).
- TAG_W, 8: BTB tag width taken from the PC above the index bits.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bp_enable  in  1  1 = predictions allowed; 0 = pred_taken forced 0.
- if_pc  in  32  current fetch PC.
- pred_taken  out  1  predict taken for if_pc.
- pred_target  out  32  predicted target; valid only when pred_taken=1.
- upd_valid  in  1  one resolved conditional branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target.
- upd_mispredict  in  1  EX detected a misprediction; qualified by upd_valid.
- br_count  out  CNT_W  resolved branches since reset.
- mispred_count  out  CNT_W  mispredicts since reset.

Behaviour:
- Storage is flops, not BRAM. Per entry: valid, tag[TAG_W], target[32], ctr[2].
- Lookup is combinational on the registered state, zero latency:
  - idx = if_pc[IDX_W+1:2]; tag = if_pc[IDX_W+TAG_W+1:IDX_W+2].
  - hit = valid[idx] & (tag match).
  - pred_taken = bp_enable & hit & ctr[idx][1].
  - pred_target = target[idx], regardless of hit.
- Update, on the rising edge when upd_valid=1, using the index/tag derived from upd_pc:
  - Hit: ctr increments on taken (saturating at 3) and decrements on not-taken (saturating at 0). target is written only if upd_taken=1.
  - Miss: allocate the entry. valid=1, tag overwritten, ctr = upd_taken ? 2'b10 : 2'b01, target = upd_target. The prior occupant is evicted.
  - br_count += 1. mispred_count += 1 if upd_mispredict. Both wrap modulo 2^CNT_W.
- upd_valid=0: no state change. upd_mispredict is ignored.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update value; the new value is visible next cycle.
- bp_enable=0: training and counting continue; only pred_taken is masked. Toggling bp_enable has no effect on state.
- Reset, asynchronous, applies even mid-update and wins over any update that cycle:
  - all valid=0, ctr=2'b01, tags/targets=0, counters=0, GHR=0.
  - Outputs during and after reset: pred_taken=0, pred_target=0, br_count=0, mispred_count=0.

Optional Feature:
- Macro: BP_GSHARE_EN.
- When defined:
  - Add an IDX_W-bit global history register (GHR), updated on upd_valid as ghr <= {ghr[IDX_W-2:0], upd_taken}.
  - Counter index = pc index XOR history. Lookup uses the live GHR.
  - Extra ports: pred_ghr out IDX_W (GHR value at lookup, piped by the core) and upd_ghr in IDX_W (snapshot used for the update index).
  - BTB valid/tag/target remain indexed by PC bits only.
  - The miss-allocate ctr write goes to the gshare-indexed counter.
- When undefined: no GHR and no extra ports; counters share the PC index with the BTB.

Decomposition:
- Package bp_pkg:
  - localparams for counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - the entry struct typedef (valid, tag, target).
  - function sat_update(ctr, taken) returning the saturated 2-bit next state.
- One natural sub-module: bp_perf_counters (br_count/mispred_count with wrap). The tables stay in the top module.

Test Plan:
- Reset, then if_pc=0x4000_0010 with bp_enable=1 -> pred_taken=0, br_count=0.
- Update pc=0x4000_0010, taken, target=0x4000_0100 -> next cycle pred_taken=1 and pred_target=0x4000_0100. Follow with two not-taken updates -> ctr 2→1→0 and pred_taken=0. A third not-taken keeps ctr=0.
- Alias eviction: train 0x4000_0010 taken, then update 0x4000_1010 (same idx, different tag) not-taken -> lookup of 0x4000_0010 misses with pred_taken=0; lookup of 0x4000_1010 gives ctr=01, pred_taken=0.
- Same-cycle lookup and update of one index -> old prediction this cycle, new prediction next cycle. With bp_enable=0 and a trained taken entry -> pred_taken=0; re-enable -> 1.
- 5 updates, 2 with upd_mispredict -> br_count=5, mispred_count=2. Preload br_count to all-ones by force, then one update -> wraps to 0.
- Assert rst asynchronously mid-stream, between clock edges, with upd_valid=1 -> all outputs 0 immediately; after release, the previously trained PC misses.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings,
// BTB entry payload and the saturating 2-bit counter step.
package bp_pkg;

  localparam int unsigned BP_TAG_W = 8;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
  } bp_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_perf_counters.sv
// Resolved-branch and mispredict counters; both wrap modulo 2^CNT_W.
module bp_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (upd_valid) begin
      br_q <= br_q + CNT_W'(1);
      if (upd_mispredict) mp_q <= mp_q + CNT_W'(1);
    end
  end

  assign br_count      = br_q;
  assign mispred_count = mp_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters and same-cycle lookup.
// Optional gshare counter indexing when BP_GSHARE_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = BP_TAG_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bp_enable,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
`ifdef BP_GSHARE_EN
  ,
  output logic [IDX_W-1:0] pred_ghr,
  input  logic [IDX_W-1:0] upd_ghr
`endif
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_LO  = IDX_W + 2;
  localparam int unsigned TAG_HI  = IDX_W + TAG_W + 1;

  bp_entry_t  btb_q [ENTRIES];
  logic [1:0] ctr_q [ENTRIES];

  logic [IDX_W-1:0] lkp_idx, lkp_cidx, upd_idx, upd_cidx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_hit, upd_hit;
  bp_entry_t        upd_entry;
  logic [1:0]       upd_ctr;
  logic             unused_pc_bits;

  assign lkp_idx = if_pc[IDX_W+1:2];
  assign lkp_tag = if_pc[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[TAG_HI:TAG_LO];
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // History shifts in each resolved outcome; the core pipes the lookup snapshot back as upd_ghr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ghr_q <= '0;
    else if (upd_valid) ghr_q <= {ghr_q[IDX_W-2:0], upd_taken};
  end

  assign lkp_cidx = lkp_idx ^ ghr_q;
  assign upd_cidx = upd_idx ^ upd_ghr;
  assign pred_ghr = ghr_q;
`else
  assign lkp_cidx = lkp_idx;
  assign upd_cidx = upd_idx;
`endif

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign lkp_hit     = btb_q[lkp_idx].valid && (btb_q[lkp_idx].tag == lkp_tag);
  assign pred_taken  = bp_enable & lkp_hit & ctr_q[lkp_cidx][1];
  assign pred_target = btb_q[lkp_idx].target;

  assign upd_hit = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);

  // Hit trains the counter (target only on taken); miss evicts and allocates.
  always_comb begin
    upd_entry = btb_q[upd_idx];
    upd_ctr   = sat_update(ctr_q[upd_cidx], upd_taken);
    if (upd_hit) begin
      if (upd_taken) upd_entry.target = upd_target;
    end else begin
      upd_entry.valid  = 1'b1;
      upd_entry.tag    = upd_tag;
      upd_entry.target = upd_target;
      upd_ctr          = upd_taken ? WT : WNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[IDX_W'(i)] <= '0;
        ctr_q[IDX_W'(i)] <= WNT;
      end
    end else if (upd_valid) begin
      btb_q[upd_idx]  <= upd_entry;
      ctr_q[upd_cidx] <= upd_ctr;
    end
  end

  bp_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .upd_valid     (upd_valid),
    .upd_mispredict(upd_mispredict),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

endmodule
